// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM requesters onto one downstream memory port.
// Data wins by default; d_streak bounds how long a pending fetch can wait.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t      state;
  logic [3:0]  d_streak;

  logic        i_pend;
  logic [31:0] i_pend_addr;
  logic [3:0]  i_pend_rmask;

  logic        d_pend;
  logic [31:0] d_pend_addr;
  logic [3:0]  d_pend_rmask;
  logic [3:0]  d_pend_wmask;
  logic [31:0] d_pend_wdata;

  logic        i_req;
  logic        d_req;
  logic        i_cand;
  logic        d_cand;
  logic        can_grant;
  logic        grant_i;
  logic        grant_d;

  logic [31:0] i_sel_addr;
  logic [3:0]  i_sel_rmask;
  logic [31:0] d_sel_addr;
  logic [3:0]  d_sel_rmask;
  logic [3:0]  d_sel_wmask;
  logic [31:0] d_sel_wdata;

  assign i_req = |i_rmask;
  assign d_req = (|d_rmask) | (|d_wmask);

  assign i_cand = i_pend | i_req;
  assign d_cand = d_pend | d_req;

  assign i_sel_addr  = i_pend ? i_pend_addr  : i_addr;
  assign i_sel_rmask = i_pend ? i_pend_rmask : i_rmask;
  assign d_sel_addr  = d_pend ? d_pend_addr  : d_addr;
  assign d_sel_rmask = d_pend ? d_pend_rmask : d_rmask;
  assign d_sel_wmask = d_pend ? d_pend_wmask : d_wmask;
  assign d_sel_wdata = d_pend ? d_pend_wdata : d_wdata;

  // Arbitrate on the response cycle too, so transactions run back-to-back.
  assign can_grant = (state == IDLE) | mem_resp;
  assign grant_d   = can_grant & d_cand &
                     ((d_streak < MAX_S) | ~i_cand);
  assign grant_i   = can_grant & i_cand & ~grant_d;

  assign i_resp  = mem_resp & (state == BUSY_I);
  assign d_resp  = mem_resp & (state == BUSY_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      d_streak     <= '0;
      i_pend       <= 1'b0;
      i_pend_addr  <= '0;
      i_pend_rmask <= '0;
      d_pend       <= 1'b0;
      d_pend_addr  <= '0;
      d_pend_rmask <= '0;
      d_pend_wmask <= '0;
      d_pend_wdata <= '0;
      mem_addr     <= '0;
      mem_rmask    <= '0;
      mem_wmask    <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_rmask <= '0;
      mem_wmask <= '0;

      if (i_req) begin
        i_pend       <= 1'b1;
        i_pend_addr  <= i_addr;
        i_pend_rmask <= i_rmask;
      end
      if (d_req) begin
        d_pend       <= 1'b1;
        d_pend_addr  <= d_addr;
        d_pend_rmask <= d_rmask;
        d_pend_wmask <= d_wmask;
        d_pend_wdata <= d_wdata;
      end

      if (grant_d) begin
        state     <= BUSY_D;
        d_pend    <= 1'b0;
        mem_addr  <= d_sel_addr;
        mem_rmask <= d_sel_rmask;
        mem_wmask <= d_sel_wmask;
        mem_wdata <= d_sel_wdata;
        if (!i_cand) begin
          d_streak <= '0;
        end else if (d_streak != 4'hF) begin
          d_streak <= d_streak + 4'd1;
        end
      end else if (grant_i) begin
        state     <= BUSY_I;
        i_pend    <= 1'b0;
        mem_addr  <= i_sel_addr;
        mem_rmask <= i_sel_rmask;
        d_streak  <= '0;
      end else if (mem_resp) begin
        state <= IDLE;
      end
    end
  end

  a_i_single: assert property (@(posedge clk) disable iff (rst)
    i_req |-> !(i_pend || (state == BUSY_I && !mem_resp)));

  a_d_single: assert property (@(posedge clk) disable iff (rst)
    d_req |-> !(d_pend || (state == BUSY_D && !mem_resp)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable
// memory responder and an in-order fetch scoreboard.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;

  int lat      = 2;
  bit rand_lat = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_rmask   (i_rmask),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_addr    (d_addr),
    .d_rmask   (d_rmask),
    .d_wmask   (d_wmask),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_addr  (mem_addr),
    .mem_rmask (mem_rmask),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h6000_0000) ? 32'h0000_0013 : ~a;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: acts just after each posedge, responds lat cycles
  // after seeing an issue cycle.
  initial begin
    logic [31:0] cur;
    int cnt;
    cnt = 0;
    cur = '0;
    mem_resp = 0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp  = 1;
          mem_rdata = rd_fn(cur);
        end
      end else if (mem_rmask != 0 || mem_wmask != 0) begin
        cur = mem_addr;
        cnt = rand_lat ? int'($urandom_range(1, 5)) : lat;
      end
    end
  end

  task automatic wait_resp(input bit want_d, output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (want_d ? d_resp : i_resp) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int dgr;
    bit f_seen;
    int nresp;
    int done;
    int issued;
    bit exp_issue;
    logic [31:0] na;
    logic [31:0] q[$];

    rst = 1;
    i_addr = '0; i_rmask = '0;
    d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_masks", {mem_rmask, mem_wmask}, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    rst = 0;
    @(negedge clk);

    // single fetch, latency 2
    lat = 2;
    i_rmask = 4'hF; i_addr = 32'h6000_0000;
    @(negedge clk);
    i_rmask = 0;
    check("sf_rmask", mem_rmask, 4'hF);
    check("sf_addr", mem_addr, 32'h6000_0000);
    check("sf_wmask", mem_wmask, 0);
    @(negedge clk);
    check("sf_rmask_pulse", mem_rmask, 0);
    check("sf_addr_hold", mem_addr, 32'h6000_0000);
    check("sf_early_resp", i_resp, 0);
    @(negedge clk);
    check("sf_i_resp", i_resp, 1);
    check("sf_i_rdata", i_rdata, 32'h13);
    check("sf_d_resp", d_resp, 0);
    @(negedge clk);

    // simultaneous requests
    i_rmask = 4'hF; i_addr = 32'h100;
    d_wmask = 4'h3; d_addr = 32'h200; d_wdata = 32'hABCD;
    @(negedge clk);
    i_rmask = 0; d_wmask = 0;
    check("sim_wmask", mem_wmask, 4'h3);
    check("sim_rmask", mem_rmask, 0);
    check("sim_wdata", mem_wdata, 32'hABCD);
    check("sim_daddr", mem_addr, 32'h200);
    wait_resp(1, ok);
    check("sim_d_resp_seen", ok, 1);
    check("sim_no_i_resp", i_resp, 0);
    @(negedge clk);
    check("sim_i_rmask", mem_rmask, 4'hF);
    check("sim_i_addr", mem_addr, 32'h100);
    wait_resp(0, ok);
    check("sim_i_resp_seen", ok, 1);
    check("sim_i_rdata", i_rdata, ~32'h100);
    @(negedge clk);

    // starvation bound
    lat = 1;
    dgr = 0; f_seen = 0;
    i_rmask = 4'hF; i_addr = 32'h1000;
    d_wmask = 4'hF; d_addr = 32'h2000; d_wdata = 32'h55;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i_rmask = 0; d_wmask = 0;
      if (mem_rmask != 0 || mem_wmask != 0) begin
        if (mem_addr == 32'h1000) begin
          if (!f_seen) begin
            f_seen = 1;
            check("stv_dgrants", dgr, 4);
            check("stv_streak_clr", dut.d_streak, 0);
          end
        end else if (!f_seen) begin
          dgr++;
        end
      end
      if (d_resp && !f_seen) d_wmask = 4'hF;
    end
    check("stv_fetch_granted", f_seen, 1);
    check("stv_streak_end", dut.d_streak, 0);

    // back-to-back random-latency fetches
    rand_lat = 1;
    done = 0; issued = 1; exp_issue = 1;
    na = 32'h8000_0000;
    i_rmask = 4'hF; i_addr = na; q.push_back(na);
    for (int c = 0; c < 3000 && done < 100; c++) begin
      @(negedge clk);
      i_rmask = 0;
      if (exp_issue) begin
        check("b2b_rmask", mem_rmask, 4'hF);
        check("b2b_addr", mem_addr, q[q.size()-1]);
        exp_issue = 0;
      end
      if (i_resp) begin
        check("b2b_rdata", i_rdata, rd_fn(q.pop_front()));
        done++;
        if (issued < 100) begin
          na = 32'h8000_0000 + 32'(issued * 4);
          i_rmask = 4'hF; i_addr = na; q.push_back(na);
          issued++;
          exp_issue = 1;
        end
      end
      if (d_resp) check("b2b_stray_d", d_resp, 0);
    end
    check("b2b_count", done, 100);
    rand_lat = 0;
    repeat (3) @(negedge clk);

    // reset in the middle of a data transaction
    lat = 3;
    d_rmask = 4'hF; d_addr = 32'h300;
    @(negedge clk);
    d_rmask = 0;
    check("rs_issue", mem_rmask, 4'hF);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rs_addr0", mem_addr, 0);
    check("rs_masks0", {mem_rmask, mem_wmask}, 0);
    check("rs_wdata0", mem_wdata, 0);
    check("rs_resp0", {i_resp, d_resp}, 0);
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i_resp || d_resp) nresp++;
    end
    check("rs_late_resp", nresp, 0);
    lat = 1;
    i_rmask = 4'hF; i_addr = 32'h400;
    @(negedge clk);
    i_rmask = 0;
    check("rs_f_issue", mem_rmask, 4'hF);
    check("rs_f_addr", mem_addr, 32'h400);
    wait_resp(0, ok);
    check("rs_f_resp", ok, 1);
    check("rs_f_rdata", i_rdata, ~32'h400);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single downstream memory port between the pipeline's instruction-fetch requester (IF) and its data-memory requester (MEM).

- Latches one-cycle request pulses from each side and issues one downstream transaction at a time.
- Routes the response back to the side that owns the transaction.
- Data requests have priority; a bounded streak counter prevents fetch starvation.
- Sits between the IF/MEM stages and the memory model or cache adapter.

## Interface

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while a fetch is pending; range 1–15.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; synchronous, active-high.
- i_addr, in, 32: fetch address.
- i_rmask, in, 4: fetch read mask; nonzero for one cycle means a request.
- i_rdata, out, 32: fetch read data.
- i_resp, out, 1: fetch response pulse.
- d_addr, in, 32: data address.
- d_rmask, in, 4: data read mask.
- d_wmask, in, 4: data write mask.
- d_wdata, in, 32: data write data.
- d_rdata, out, 32: data read data.
- d_resp, out, 1: data response pulse.
- mem_addr, out, 32: downstream address.
- mem_rmask, out, 4: downstream read mask.
- mem_wmask, out, 4: downstream write mask.
- mem_wdata, out, 32: downstream write data.
- mem_rdata, in, 32: downstream read data.
- mem_resp, in, 1: downstream response pulse.

## Operation

**Request capture**
- A request is a cycle with |i_rmask on the fetch side, or (|d_rmask | |d_wmask) on the data side.
- Each side has one pending slot holding addr, masks and wdata. It is captured on the request cycle.
- Requesters never issue a second request before their resp. The arbiter does not check this; SVA asserts it.

**State machine: IDLE, BUSY_I, BUSY_D**
- IDLE, with both pending slots and the current-cycle request as candidates:
  - If a data candidate exists and d_streak < MAX_D_STREAK, or no fetch candidate exists: grant data, go to BUSY_D.
  - Else if a fetch candidate exists: grant fetch, go to BUSY_I.
  - Granting clears that side's pending slot and loads the mem_* output registers.
- BUSY_I: hold mem_* stable until mem_resp, then return to IDLE.
- BUSY_D: same as BUSY_I.
- mem_rmask and mem_wmask are nonzero for exactly one cycle, the first cycle of BUSY_x. They are zero otherwise. mem_addr and mem_wdata hold their values for the whole transaction.

**Response routing** (combinational)
- i_resp = mem_resp & (state==BUSY_I).
- d_resp = mem_resp & (state==BUSY_D).
- i_rdata and d_rdata = mem_rdata, unconditionally.

**Anti-starvation: d_streak (4-bit)**
- Increments on a data grant while a fetch candidate exists; saturates at 15.
- Clears on any fetch grant, or on a data grant with no fetch candidate.

**Widths**
- Address, masks and data pass through unmodified; no alignment is applied.
- A data request with both rmask and wmask nonzero is forwarded as-is.

**Reset**
- state=IDLE, both pending slots empty, d_streak=0.
- All mem_* outputs 0; i_resp and d_resp 0.
- Reset mid-transaction abandons it. A mem_resp arriving after reset while in IDLE is ignored: no i_resp or d_resp.

## Timing

- Request at cycle t with the arbiter IDLE and nothing pending: mem_rmask/wmask asserted at t+1 (registered outputs).
- mem_resp at cycle r: the matching resp and rdata at r (zero added latency); state is IDLE at r+1.
- A request arriving in cycle r, or pending at r, issues downstream at r+1. This gives back-to-back transactions with no bubble beyond the registered issue.
- A request on the side being responded to, in that same cycle r, is legal; it is captured into pending.
- Simultaneous fetch and data requests while IDLE: data issues at t+1. Fetch stays pending and issues the cycle after data's mem_resp.
- Unloaded round trip = downstream latency + 1 cycle.
- mem_resp while IDLE (spurious): ignored.

## Test plan

- **Single fetch.** i_rmask=4'hF, i_addr=0x6000_0000 at cycle 1; memory responds 2 cycles after issue with 0x0000_0013.
  - Expect mem_rmask=F and mem_addr=0x6000_0000 at cycle 2.
  - Expect i_resp=1 with i_rdata=0x13 at cycle 4; d_resp stays 0.
- **Simultaneous requests.** Same cycle: i_rmask=F at 0x100 and d_wmask=4'h3 at 0x200 with d_wdata=0xABCD.
  - Data issues first: mem_wmask=3, mem_wdata=0xABCD.
  - Fetch issues the cycle after d_resp; i_resp follows.
- **Starvation bound.** MAX_D_STREAK=4; fetch pending while data re-requests on every d_resp.
  - Exactly 4 data grants occur, then the fetch is granted, then d_streak=0.
- **Back-to-back.** A fetch is issued in the same cycle as i_resp.
  - The next mem_rmask=F appears the next cycle.
  - No lost or duplicated requests over 100 random-latency (1–5 cycle) fetches. Scoreboard checks addr/rdata order.
- **Reset mid-transaction.** rst asserted during BUSY_D.
  - All outputs are 0 the next cycle.
  - A late mem_resp produces no d_resp or i_resp.
  - A fetch issued after reset completes normally.
